// File: rtl/iccm_dump_tx.sv
// iccm_dump_tx -- UART readback transmitter for the ICCM program path.
//
// On an accepted start_i the block reads num_words_i 32-bit words from the
// instruction SRAM, starting at word address 0. Each word is sent as four
// 8N1 UART frames, least-significant byte first.
//
// Ports:
//   clk_i          system clock (only clock)
//   rst_ni         synchronous active-low reset
//   start_i        one-cycle dump request, ignored while busy
//   num_words_i    words to send (0..2^ADDR_W), sampled on accepted start
//   clks_per_bit_i UART bit period in clk_i cycles (0 treated as 1)
//   mem_csb_o      SRAM chip select, active low, read only
//   mem_addr_o     SRAM word address
//   mem_rdata_i    SRAM read data, valid the cycle after mem_csb_o=0
//   tx_o           UART serial output, idles high
//   busy_o         dump in progress
//   done_o         one-cycle completion pulse
//
// Optional feature: define ICCM_DUMP_CHECKSUM_EN to append one frame that
// carries the mod-256 sum of every data byte sent.
module iccm_dump_tx #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_words_i,
  input  logic [15:0]       clks_per_bit_i,
  output logic              mem_csb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_START, S_DATA, S_STOP, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       period_q, period_d;
  logic [15:0]       tick_q, tick_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic [2:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              csb_q, csb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef ICCM_DUMP_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              chk_q, chk_d;
`endif

  logic              tick_last;
  logic              more_words;
  logic [31:0]       word_rot;

  assign tick_last  = (tick_q == period_q - 16'd1);
  // addr_q is the index of the word just sent; addr_q+1 words are done.
  assign more_words = (({1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1}) < num_q);
  // The word is rotated one bit per data bit, so after a byte the byte just
  // sent sits in [31:24] and the next byte is already in [7:0].
  assign word_rot   = {word_q[0], word_q[31:1]};

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    addr_d   = addr_q;
    period_d = period_q;
    tick_d   = tick_q;
    word_d   = word_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    csb_d    = 1'b1;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef ICCM_DUMP_CHECKSUM_EN
    sum_d    = sum_q;
    chk_d    = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_d    = num_words_i;
          period_d = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
          addr_d   = '0;
          tick_d   = '0;
`ifdef ICCM_DUMP_CHECKSUM_EN
          sum_d    = 8'h00;
          chk_d    = 1'b0;
`endif
          if (num_words_i == '0) begin
`ifdef ICCM_DUMP_CHECKSUM_EN
            // Empty dump still emits the (zero) checksum frame.
            chk_d   = 1'b1;
            word_d  = 32'h0;
            byte_d  = 2'd3;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = S_START;
`else
            done_d  = 1'b1;
            state_d = S_DONE;
`endif
          end else begin
            csb_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        word_d  = mem_rdata_i;
        byte_d  = 2'd0;
        tick_d  = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (tick_last) begin
          tick_d  = '0;
          bit_d   = 3'd0;
          tx_d    = word_q[0];
          state_d = S_DATA;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tick_last) begin
          tick_d = '0;
          word_d = word_rot;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
`ifdef ICCM_DUMP_CHECKSUM_EN
            if (!chk_q) sum_d = sum_q + word_rot[31:24];
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = word_q[1];
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      S_STOP: begin
        if (tick_last) begin
          tick_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            tx_d    = 1'b0;
            state_d = S_START;
          end else if (more_words) begin
            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            csb_d   = 1'b0;
            state_d = S_READ;
`ifdef ICCM_DUMP_CHECKSUM_EN
          end else if (!chk_q) begin
            chk_d   = 1'b1;
            word_d  = {24'h0, sum_q};
            byte_d  = 2'd3;
            tx_d    = 1'b0;
            state_d = S_START;
`endif
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      addr_q   <= '0;
      period_q <= 16'd1;
      tick_q   <= '0;
      word_q   <= '0;
      byte_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      csb_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ICCM_DUMP_CHECKSUM_EN
      sum_q    <= 8'h00;
      chk_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      addr_q   <= addr_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      word_q   <= word_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      csb_q    <= csb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ICCM_DUMP_CHECKSUM_EN
      sum_q    <= sum_d;
      chk_q    <= chk_d;
`endif
    end
  end

  assign tx_o       = tx_q;
  assign mem_csb_o  = csb_q;
  assign mem_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
